// File: rtl/i2s_stereo_transmitter_if.sv
// Sample bus from the audio mixer into the I2S transmitter.
// One stereo frame moves per valid/ready handshake.
interface i2s_stereo_transmitter_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] sampleLeft;
  logic [SAMPLE_WIDTH-1:0] sampleRight;
  logic                    sampleValid;
  logic                    sampleReady;

  modport master (output sampleLeft, output sampleRight, output sampleValid, input sampleReady);
  modport slave  (input sampleLeft, input sampleRight, input sampleValid, output sampleReady);
endinterface

// File: rtl/i2s_stereo_transmitter.sv
// Stereo I2S transmitter: divides clk into bitclk/lrclk and shifts frames out MSB first.
// Optional macro I2S_TX_REPEAT_ON_UNDERRUN_EN repeats the last frame on underrun instead of sending zeros.
module i2s_stereo_transmitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 16,
  parameter int CLK_DIV      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  i2s_stereo_transmitter_if.slave bus,
  output logic                    bitclk,
  output logic                    lrclk,
  output logic                    dataOut,
  output logic                    underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam int PAD_W      = SLOT_WIDTH - SAMPLE_WIDTH;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_RIGHT = IDX_W'(SLOT_WIDTH);

  logic [DIV_W-1:0]        divider, dividerNext;
  logic                    bitclkNext;
  logic [IDX_W-1:0]        bitIndex, bitIndexNext, bitAhead;
  logic                    lrclkNext;
  logic [FRAME_BITS-1:0]   shiftReg, shiftNext, bufFrame, loadFrame;
  logic [SAMPLE_WIDTH-1:0] leftBuf, rightBuf;
  logic                    full, fullNext;
  logic                    started, startedNext;
  logic                    underrunNext;
  logic                    fallTick, frameLoad, accept;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [FRAME_BITS-1:0]   heldFrame, heldFrameNext;
`endif

  assign bus.sampleReady = !full;
  assign accept          = bus.sampleValid && !full;
  assign fallTick        = (divider == DIV_LAST) && bitclk;
  assign frameLoad       = fallTick && (bitIndex == IDX_LAST);
  assign dataOut         = shiftReg[FRAME_BITS-1];

  // Each slot is the sample left-justified with zero padding below its LSB.
  always_comb begin
    bufFrame = {SLOT_WIDTH'(leftBuf) << PAD_W, SLOT_WIDTH'(rightBuf) << PAD_W};
  end

  always_comb begin
    dividerNext  = (divider == DIV_LAST) ? '0 : divider + DIV_W'(1);
    bitclkNext   = (divider == DIV_LAST) ? ~bitclk : bitclk;
    bitIndexNext = bitIndex;
    shiftNext    = shiftReg;
    lrclkNext    = lrclk;
    fullNext     = full;
    startedNext  = started | accept;
    underrunNext = frameLoad && !full && started;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    heldFrameNext = (frameLoad && full) ? bufFrame : heldFrame;
    loadFrame     = full ? bufFrame : heldFrame;
`else
    loadFrame     = full ? bufFrame : '0;
`endif

    if (fallTick) begin
      bitIndexNext = frameLoad ? '0 : bitIndex + IDX_W'(1);
      shiftNext    = frameLoad ? loadFrame : {shiftReg[FRAME_BITS-2:0], 1'b0};
    end

    // Word select reflects the bit after the one being sent, so it leads data by one bit.
    bitAhead = (bitIndexNext == IDX_LAST) ? '0 : bitIndexNext + IDX_W'(1);
    if (fallTick) begin
      lrclkNext = (bitAhead >= IDX_RIGHT);
    end

    // The accept wins only when the buffer was empty, so a coinciding load cannot drop it.
    if (accept) begin
      fullNext = 1'b1;
    end else if (frameLoad) begin
      fullNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divider   <= '0;
      bitclk    <= 1'b0;
      bitIndex  <= IDX_LAST;
      lrclk     <= 1'b0;
      shiftReg  <= '0;
      full      <= 1'b0;
      started   <= 1'b0;
      underrun  <= 1'b0;
      leftBuf   <= '0;
      rightBuf  <= '0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      heldFrame <= '0;
`endif
    end else begin
      divider   <= dividerNext;
      bitclk    <= bitclkNext;
      bitIndex  <= bitIndexNext;
      lrclk     <= lrclkNext;
      shiftReg  <= shiftNext;
      full      <= fullNext;
      started   <= startedNext;
      underrun  <= underrunNext;
      if (accept) begin
        leftBuf  <= bus.sampleLeft;
        rightBuf <= bus.sampleRight;
      end
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      heldFrame <= heldFrameNext;
`endif
    end
  end

endmodule

// File: tb/tb_i2s_stereo_transmitter.sv
// Directed bench for i2s_stereo_transmitter: a 16/16/2 instance for framing and handshake,
// and a 12/16/1 instance for zero padding; bits are logged on bitclk rising edges.
module tb_i2s_stereo_transmitter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bitclk, lrclk, dataOut, underrun;
  logic bitclkB, lrclkB, dataOutB, underrunB;
  int   assertions = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  i2s_stereo_transmitter_if #(.SAMPLE_WIDTH(16)) busA ();
  i2s_stereo_transmitter_if #(.SAMPLE_WIDTH(12)) busB ();

  i2s_stereo_transmitter #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .bus(busA),
    .bitclk(bitclk), .lrclk(lrclk), .dataOut(dataOut), .underrun(underrun)
  );

  i2s_stereo_transmitter #(.SAMPLE_WIDTH(12), .SLOT_WIDTH(16), .CLK_DIV(1)) dutNarrow (
    .clk(clk), .reset(reset), .bus(busB),
    .bitclk(bitclkB), .lrclk(lrclkB), .dataOut(dataOutB), .underrun(underrunB)
  );

  // Rise k after reset carries bit (k-1) mod 32 of frame (k-1)/32; rise 0 is the idle bit before the first load.
  logic bitLog [0:1023];
  logic lrLog  [0:1023];
  int   riseCount = 0;
  int   cycleCount = 0;
  int   underrunCount = 0;
  int   firstUnderrunCycle = -1;
  int   underrunWide = 0;
  logic prevBitclk = 1'b0;
  logic prevUnderrun = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      riseCount = 0; cycleCount = 0; underrunCount = 0;
      firstUnderrunCycle = -1; underrunWide = 0;
      prevBitclk = 1'b0; prevUnderrun = 1'b0;
    end else begin
      cycleCount++;
      if (bitclk && !prevBitclk && riseCount < 1024) begin
        bitLog[riseCount] = dataOut;
        lrLog[riseCount]  = lrclk;
        riseCount++;
      end
      if (underrun) begin
        if (prevUnderrun) underrunWide++;
        else begin
          underrunCount++;
          if (firstUnderrunCycle < 0) firstUnderrunCycle = cycleCount;
        end
      end
      prevBitclk = bitclk;
      prevUnderrun = underrun;
    end
  end

  function automatic logic [31:0] frameBits(input int f);
    logic [31:0] v;
    for (int b = 0; b < 32; b++) v[31-b] = bitLog[1 + 32*f + b];
    return v;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    busA.sampleValid = 1'b0;
    busB.sampleValid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic sendFrameA(input logic [15:0] l, input logic [15:0] r);
    int waited = 0;
    busA.sampleLeft = l;
    busA.sampleRight = r;
    busA.sampleValid = 1'b1;
    while (busA.sampleReady !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    assertions++;
    if (busA.sampleReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL handshake_timeout: sampleReady=%b required 1", busA.sampleReady);
    end
    @(negedge clk);
  endtask

  task automatic waitRises(input int target, input int budget);
    int n = 0;
    while (riseCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    assertions++;
    if (riseCount < target) begin
      failures++;
      $display("[TB] FAIL rise_timeout: got %0d bitclk rises required %0d", riseCount, target);
    end
  endtask

  task automatic test_reset();
    applyReset();
    assertions += 5;
    if (bitclk !== 1'b0) begin failures++; $display("[TB] FAIL reset_bitclk: got %b required 0", bitclk); end
    if (lrclk !== 1'b0) begin failures++; $display("[TB] FAIL reset_lrclk: got %b required 0", lrclk); end
    if (dataOut !== 1'b0) begin failures++; $display("[TB] FAIL reset_dataOut: got %b required 0", dataOut); end
    if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun: got %b required 0", underrun); end
    if (busA.sampleReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b required 1", busA.sampleReady); end
  endtask

  task automatic test_idle();
    int   run = 0;
    int   toggles = 0;
    int   badRuns = 0;
    int   dataOnes = 0;
    int   lrBad = 0;
    logic last;
    releaseReset();
    last = bitclk;
    repeat (300) begin
      @(negedge clk);
      if (bitclk !== last) begin
        if (toggles > 0 && run != 2) badRuns++;
        toggles++;
        run = 1;
        last = bitclk;
      end else run++;
      if (dataOut !== 1'b0) dataOnes++;
    end
    @(negedge clk);
    for (int k = 0; k < riseCount; k++) begin
      if (lrLog[k] !== ((((k + 31) % 32 + 1) % 32) >= 16)) lrBad++;
    end
    assertions += 6;
    if (toggles != 150) begin failures++; $display("[TB] FAIL idle_toggles: got %0d required 150", toggles); end
    if (badRuns != 0) begin failures++; $display("[TB] FAIL idle_bitclk_period: got %0d bad half-periods required 0", badRuns); end
    if (dataOnes != 0) begin failures++; $display("[TB] FAIL idle_dataOut: got %0d high samples required 0", dataOnes); end
    if (underrunCount != 0) begin failures++; $display("[TB] FAIL idle_underrun: got %0d pulses required 0", underrunCount); end
    if (riseCount != 75) begin failures++; $display("[TB] FAIL idle_rises: got %0d required 75", riseCount); end
    if (lrBad != 0) begin failures++; $display("[TB] FAIL idle_lrclk: got %0d wrong bits required 0", lrBad); end
  endtask

  task automatic test_single_frame();
    applyReset();
    releaseReset();
    sendFrameA(16'hA5C3, 16'h0F81);
    busA.sampleValid = 1'b0;
    assertions += 4;
    if (busA.sampleReady !== 1'b0) begin failures++; $display("[TB] FAIL ready_after_accept: got %b required 0", busA.sampleReady); end
    repeat (2) @(negedge clk);
    if (busA.sampleReady !== 1'b0) begin failures++; $display("[TB] FAIL ready_in_load_cycle: got %b required 0", busA.sampleReady); end
    @(negedge clk);
    if (busA.sampleReady !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_load: got %b required 1", busA.sampleReady); end
    waitRises(33, 400);
    if (frameBits(0) !== 32'hA5C3_0F81) begin failures++; $display("[TB] FAIL single_frame_bits: got %h required a5c30f81", frameBits(0)); end
  endtask

  task automatic test_underrun();
    logic [31:0] expectFrame;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    expectFrame = 32'hA5C3_0F81;
`else
    expectFrame = 32'h0;
`endif
    waitRises(65, 400);
    assertions += 4;
    if (frameBits(1) !== expectFrame) begin failures++; $display("[TB] FAIL underrun_frame_bits: got %h required %h", frameBits(1), expectFrame); end
    if (underrunCount != 1) begin failures++; $display("[TB] FAIL underrun_count: got %0d required 1", underrunCount); end
    if (firstUnderrunCycle != 132) begin failures++; $display("[TB] FAIL underrun_cycle: got %0d required 132", firstUnderrunCycle); end
    if (underrunWide != 0) begin failures++; $display("[TB] FAIL underrun_width: got %0d extra cycles required 0", underrunWide); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] frames [4];
    frames[0] = 32'h1234_ABCD;
    frames[1] = 32'h8001_7FFE;
    frames[2] = 32'hFFFF_0000;
    frames[3] = 32'h5A5A_C3C3;
    applyReset();
    releaseReset();
    for (int i = 0; i < 4; i++) sendFrameA(frames[i][31:16], frames[i][15:0]);
    busA.sampleValid = 1'b0;
    waitRises(129, 700);
    for (int i = 0; i < 4; i++) begin
      assertions++;
      if (frameBits(i) !== frames[i]) begin failures++; $display("[TB] FAIL b2b_frame%0d: got %h required %h", i, frameBits(i), frames[i]); end
    end
    assertions++;
    if (underrunCount != 0) begin failures++; $display("[TB] FAIL b2b_underrun: got %0d pulses required 0", underrunCount); end
  endtask

  task automatic test_reset_mid_frame();
    int ones = 0;
    applyReset();
    releaseReset();
    sendFrameA(16'h1111, 16'h2222);
    sendFrameA(16'h3C3C, 16'hC3C3);
    busA.sampleValid = 1'b0;
    waitRises(22, 200);
    assertions += 8;
    if (busA.sampleReady !== 1'b0 || lrclk !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_precondition: ready=%b lrclk=%b required 0 and 1", busA.sampleReady, lrclk);
    end
    reset = 1'b1;
    @(negedge clk);
    if (bitclk !== 1'b0) begin failures++; $display("[TB] FAIL midreset_bitclk: got %b required 0", bitclk); end
    if (lrclk !== 1'b0) begin failures++; $display("[TB] FAIL midreset_lrclk: got %b required 0", lrclk); end
    if (dataOut !== 1'b0) begin failures++; $display("[TB] FAIL midreset_dataOut: got %b required 0", dataOut); end
    if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL midreset_underrun: got %b required 0", underrun); end
    if (busA.sampleReady !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready: got %b required 1", busA.sampleReady); end
    releaseReset();
    waitRises(70, 400);
    for (int k = 0; k < riseCount; k++) if (bitLog[k] !== 1'b0) ones++;
    if (ones != 0) begin failures++; $display("[TB] FAIL midreset_discard: got %0d high bits required 0", ones); end
    if (underrunCount != 0) begin failures++; $display("[TB] FAIL midreset_underrun_after: got %0d pulses required 0", underrunCount); end
  endtask

  task automatic test_narrow();
    logic [31:0] bitsB;
    int   risesB = 0;
    int   badToggle = 0;
    logic prevB;
    applyReset();
    busB.sampleLeft = 12'h801;
    busB.sampleRight = 12'h7FF;
    busB.sampleValid = 1'b1;
    prevB = bitclkB;
    releaseReset();
    bitsB = '0;
    repeat (100) begin
      @(negedge clk);
      busB.sampleValid = 1'b0;
      if (bitclkB === prevB) badToggle++;
      if (bitclkB && !prevB) begin
        if (risesB >= 1 && risesB <= 32) bitsB[32 - risesB] = dataOutB;
        risesB++;
      end
      prevB = bitclkB;
    end
    assertions += 3;
    if (bitsB[31:16] !== 16'h8010) begin failures++; $display("[TB] FAIL narrow_left_slot: got %h required 8010", bitsB[31:16]); end
    if (bitsB[15:0] !== 16'h7FF0) begin failures++; $display("[TB] FAIL narrow_right_slot: got %h required 7ff0", bitsB[15:0]); end
    if (badToggle != 0) begin failures++; $display("[TB] FAIL narrow_bitclk_period: got %0d missed toggles required 0", badToggle); end
  endtask

  initial begin
    busA.sampleLeft = '0; busA.sampleRight = '0; busA.sampleValid = 1'b0;
    busB.sampleLeft = '0; busB.sampleRight = '0; busB.sampleValid = 1'b0;
    test_reset();
    test_idle();
    test_single_frame();
    test_underrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_narrow();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
